rx_cic_iq_pack: RTL and testbench

- Sits directly downstream of the RX CIC decimator.
- Consumes its channel-interleaved Avalon-ST stream: 32-bit samples, channel 0 = I, channel 1 = Q.
- Pairs I/Q, applies a rate-dependent normalising right shift with rounding and saturation to OUT_W bits, and buffers pairs in a small FIFO.
- Feeds the compensation FIR with one I/Q pair per valid/ready handshake.

---
 rtl/rx_pkg.sv | 59 +++++
 rtl/rx_iq_fifo.sv | 58 +++++
 rtl/rx_cic_iq_pack.sv | 168 ++++++++++++++++
 tb/tb_rx_cic_iq_pack.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and the round/saturate helper for the RX CIC I/Q packer.
// Widths here must match the IN_W/OUT_W/SHIFT_W parameters of rx_cic_iq_pack.
package rx_pkg;

    localparam int RX_IN_W    = 32;
    localparam int RX_OUT_W   = 24;
    localparam int RX_SHIFT_W = 5;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    typedef enum logic {
        WAIT_I,
        HAVE_I
    } fsm_e;

    typedef struct packed {
        logic signed [RX_OUT_W-1:0] i;
        logic signed [RX_OUT_W-1:0] q;
    } iq_pair_t;

    typedef struct packed {
        logic signed [RX_OUT_W-1:0] v;
        logic                       sat;
    } rs_t;

    // One extra bit of headroom so x + 2^(s-1) can never wrap before the shift.
    function automatic rs_t round_sat(input logic signed [RX_IN_W-1:0] x,
                                      input logic [RX_SHIFT_W-1:0]     s);
        logic signed [RX_IN_W:0] ext;
        logic signed [RX_IN_W:0] bias;
        logic signed [RX_IN_W:0] v;
        logic signed [RX_IN_W:0] smax;
        logic signed [RX_IN_W:0] smin;
        rs_t r;
        ext  = {x[RX_IN_W-1], x};
        bias = '0;
        v    = ext;
        if (s != '0) begin
            bias = {{RX_IN_W{1'b0}}, 1'b1} << (s - 1'b1);
            v    = (ext + bias) >>> s;
        end
        smax = '0;
        smax[RX_OUT_W-2:0] = '1;
        smin = '1;
        smin[RX_OUT_W-2:0] = '0;
        r.v   = v[RX_OUT_W-1:0];
        r.sat = 1'b0;
        if (v > smax) begin
            r.v   = smax[RX_OUT_W-1:0];
            r.sat = 1'b1;
        end else if (v < smin) begin
            r.v   = smin[RX_OUT_W-1:0];
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_iq_fifo.sv
// Generic first-word-fall-through FIFO; the head word is visible on rdata
// whenever valid is high. DEPTH must be a power of two, at least 2.
module rx_iq_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_cic_iq_pack.sv
// Pairs interleaved I/Q samples from the RX CIC, normalises them with a rounding
// right shift and saturation, and queues pairs for the compensation FIR.
// Define RX_IQ_PACK_SATCNT_EN to add the sat_clr / sat_count saturation counter.
module rx_cic_iq_pack
    import rx_pkg::*;
#(
    parameter int IN_W       = RX_IN_W,
    parameter int OUT_W      = RX_OUT_W,
    parameter int SHIFT_W    = RX_SHIFT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_channel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_startofpacket,
    input  logic                    in_endofpacket,
    input  logic [1:0]              in_error,
    input  logic [SHIFT_W-1:0]      shift,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_pulse,
    output logic                    seq_err
`ifdef RX_IQ_PACK_SATCNT_EN
    ,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_e                     state;
    fsm_e                     state_nx;
    logic                     accept;
    logic                     load_i;
    logic                     load_pair;
    logic                     set_err;

    logic signed [IN_W-1:0]   i_p0;
    logic [SHIFT_W-1:0]       shift_p0;
    logic signed [IN_W-1:0]   i_p1;
    logic signed [IN_W-1:0]   q_p1;
    logic [SHIFT_W-1:0]       shift_p1;
    logic                     vld_p1;

    rs_t                      rs_i;
    rs_t                      rs_q;
    iq_pair_t                 pair_p1;
    iq_pair_t                 head;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_valid;

    // Counting the pipe slot as occupied guarantees every accepted pair has room.
    assign in_ready = !reset && ((32'(fifo_count) + 32'(vld_p1)) < 32'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx  = state;
        load_i    = 1'b0;
        load_pair = 1'b0;
        set_err   = 1'b0;
        if (accept) begin
            if (in_error != 2'b00) begin
                state_nx = WAIT_I;
                set_err  = 1'b1;
            end else begin
                if ((in_channel == CH_I && !in_startofpacket) ||
                    (in_channel == CH_Q && !in_endofpacket)) begin
                    set_err = 1'b1;
                end
                case (state)
                    WAIT_I: begin
                        if (in_channel == CH_I) begin
                            load_i   = 1'b1;
                            state_nx = HAVE_I;
                        end else begin
                            set_err  = 1'b1;
                        end
                    end
                    HAVE_I: begin
                        if (in_channel == CH_Q) begin
                            load_pair = 1'b1;
                            state_nx  = WAIT_I;
                        end else begin
                            load_i    = 1'b1;
                            set_err   = 1'b1;
                        end
                    end
                    default: state_nx = WAIT_I;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_I;
            vld_p1    <= 1'b0;
            seq_err   <= 1'b0;
            sat_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            vld_p1    <= load_pair;
            seq_err   <= seq_err | set_err;
            sat_pulse <= vld_p1 && (rs_i.sat || rs_q.sat);
        end
    end

    // Stage p0: held I sample and the shift captured with it.
    always_ff @(posedge clk) begin
        if (load_i) begin
            i_p0     <= in_data;
            shift_p0 <= shift;
        end
    end

    // Stage p1: complete raw pair awaiting normalisation and FIFO write.
    always_ff @(posedge clk) begin
        if (load_pair) begin
            i_p1     <= i_p0;
            q_p1     <= in_data;
            shift_p1 <= shift_p0;
        end
    end

    always_comb begin
        rs_i      = round_sat(i_p1, shift_p1);
        rs_q      = round_sat(q_p1, shift_p1);
        pair_p1.i = rs_i.v;
        pair_p1.q = rs_q.v;
    end

    rx_iq_fifo #(
        .WIDTH ($bits(iq_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vld_p1),
        .wdata (pair_p1),
        .pop   (out_ready),
        .rdata (head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_i     = fifo_valid ? head.i : '0;
    assign out_q     = fifo_valid ? head.q : '0;

`ifdef RX_IQ_PACK_SATCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (sat_pulse && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_cic_iq_pack.sv
// Self-checking bench for rx_cic_iq_pack: directed vector table, corner-case
// sequences and a randomized stream against an arithmetic reference model.
module tb_rx_cic_iq_pack;

    localparam int IN_W       = 32;
    localparam int OUT_W      = 24;
    localparam int SHIFT_W    = 5;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [IN_W-1:0]    in_data = '0;
    logic               in_channel = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_startofpacket = 1'b0;
    logic               in_endofpacket = 1'b0;
    logic [1:0]         in_error = 2'b00;
    logic [SHIFT_W-1:0] shift = '0;
    logic [OUT_W-1:0]   out_i;
    logic [OUT_W-1:0]   out_q;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               sat_pulse;
    logic               seq_err;
`ifdef RX_IQ_PACK_SATCNT_EN
    logic               sat_clr = 1'b0;
    logic [15:0]        sat_count;
`endif

    always #5 clk = ~clk;

    rx_cic_iq_pack #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .SHIFT_W    (SHIFT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_error         (in_error),
        .shift            (shift),
        .out_i            (out_i),
        .out_q            (out_q),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sat_pulse        (sat_pulse),
        .seq_err          (seq_err)
`ifdef RX_IQ_PACK_SATCNT_EN
        ,
        .sat_clr          (sat_clr),
        .sat_count        (sat_count)
`endif
    );

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        int          s;
        logic [23:0] ei;
        logic [23:0] eq;
        logic        esat;
    } vec_t;

    typedef struct {
        logic [23:0] i;
        logic [23:0] q;
    } exp_t;

    vec_t vecs [8];
    exp_t expq [$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Round half up as floor((x + 2^(s-1)) / 2^s), then clamp to 24-bit signed.
    function automatic logic [23:0] model(input logic [31:0] raw, input int s, output bit clip);
        longint x, num, den, v;
        x = longint'($signed(raw));
        if (s == 0) begin
            v = x;
        end else begin
            den = longint'(1) << s;
            num = x + den / 2;
            v   = num / den;
            if ((num % den != 0) && (num < 0)) v = v - 1;
        end
        clip = 1'b0;
        if (v > 64'sd8388607) begin
            v = 64'sd8388607;
            clip = 1'b1;
        end else if (v < -64'sd8388608) begin
            v = -64'sd8388608;
            clip = 1'b1;
        end
        return v[23:0];
    endfunction

    task automatic push_exp(input logic [31:0] i, input logic [31:0] q, input int s);
        exp_t e;
        bit ci, cq;
        e.i = model(i, s, ci);
        e.q = model(q, s, cq);
        expq.push_back(e);
        if (ci || cq) exp_sat++;
    endtask

    task automatic send(input logic ch, input logic [31:0] d, input logic sop,
                        input logic eop, input logic [1:0] err);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) note_fail("in_ready_timeout");
        in_valid         = 1'b1;
        in_channel       = ch;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_error         = err;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 2'b00;
    endtask

    task automatic send_pair(input logic [31:0] i, input logic [31:0] q, input int s);
        shift = SHIFT_W'(s);
        send(1'b0, i, 1'b1, 1'b0, 2'b00);
        send(1'b1, q, 1'b0, 1'b1, 2'b00);
    endtask

    // Called right after the Q handshake with an empty FIFO.
    task automatic pop_check(input string name, input logic [23:0] ei,
                             input logic [23:0] eq, input logic esat);
        chk({name, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_i"}, out_i, ei);
        chk({name, "_q"}, out_q, eq);
        chk({name, "_sat"}, sat_pulse, esat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_satoff"}, sat_pulse, 1'b0);
        chk({name, "_empty"}, out_valid, 1'b0);
    endtask

    task automatic collect(input int n, input bit rnd, output int sats);
        int   got = 0;
        int   cyc = 0;
        exp_t e;
        sats = 0;
        while (got < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (sat_pulse) sats++;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                got++;
                if (expq.size() == 0) begin
                    note_fail("scoreboard_underflow");
                end else begin
                    e = expq.pop_front();
                    chk("sb_pair", {out_i, out_q}, {e.i, e.q});
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("collect_count", 64'(got), 64'(n));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 33554431)) - 32'd16777216;
            default: return 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sats;
        logic [31:0] di, dq;
        int s;

        vecs[0] = '{32'h00000123, 32'hFFFFFF00, 0,  24'h000123, 24'hFFFF00, 1'b0};
        vecs[1] = '{32'h00000018, 32'h00000017, 4,  24'h000002, 24'h000001, 1'b0};
        vecs[2] = '{32'hFFFFFFE8, 32'h00000008, 4,  24'hFFFFFF, 24'h000001, 1'b0};
        vecs[3] = '{32'h00800000, 32'hFF7FFFFF, 0,  24'h7FFFFF, 24'h800000, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 31, 24'h000001, 24'hFFFFFF, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 8,  24'h7FFFFF, 24'h800000, 1'b1};
        vecs[6] = '{32'h007FFFFF, 32'hFF800000, 0,  24'h7FFFFF, 24'h800000, 1'b0};
        vecs[7] = '{32'h00000010, 32'hFFFFFFF0, 5,  24'h000001, 24'h000000, 1'b0};

        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_i", out_i, 24'h0);
        chk("rst_out_q", out_q, 24'h0);
        chk("rst_sat_pulse", sat_pulse, 1'b0);
        chk("rst_seq_err", seq_err, 1'b0);
        #11;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        for (int k = 0; k < 8; k++) begin
            send_pair(vecs[k].i, vecs[k].q, vecs[k].s);
            pop_check($sformatf("vec%0d", k), vecs[k].ei, vecs[k].eq, vecs[k].esat);
        end
        chk("vec_seq_err", seq_err, 1'b0);

        // Shift changes between I and Q must not affect the pair in flight.
        shift = 5'd4;
        send(1'b0, 32'h100, 1'b1, 1'b0, 2'b00);
        shift = 5'd0;
        send(1'b1, 32'h100, 1'b0, 1'b1, 2'b00);
        pop_check("midshift", 24'h000010, 24'h000010, 1'b0);

        // Backpressure: four pairs fill FIFO plus pipe, two more wait for space.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(32'(k * 16 + 1), 32'(-(k + 1)), 0);
            send_pair(32'(k * 16 + 1), 32'(-(k + 1)), 0);
            if (k == 2) chk("bp_ready_after3", in_ready, 1'b1);
        end
        chk("bp_ready_after4", in_ready, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_ready_held", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        fork
            begin
                for (int k = 4; k < 6; k++) begin
                    push_exp(32'(k * 16 + 1), 32'(-(k + 1)), 0);
                    send_pair(32'(k * 16 + 1), 32'(-(k + 1)), 0);
                end
            end
            collect(6, 1'b0, sats);
        join
        chk("bp_left", 64'(expq.size()), 64'd0);

        // Randomized stream with random backpressure and mid-pair shift changes.
        exp_sat = 0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    s  = int'($urandom_range(0, 31));
                    di = pick();
                    dq = pick();
                    push_exp(di, dq, s);
                    shift = SHIFT_W'(s);
                    send(1'b0, di, 1'b1, 1'b0, 2'b00);
                    if ($urandom_range(0, 3) == 0) shift = SHIFT_W'($urandom_range(0, 31));
                    send(1'b1, dq, 1'b0, 1'b1, 2'b00);
                end
            end
            collect(150, 1'b1, sats);
        join
        chk("rand_sat_count", 64'(sats), 64'(exp_sat));
        chk("rand_seq_err", seq_err, 1'b0);

        // Q with no preceding I is dropped.
        shift = 5'd0;
        send(1'b1, 32'h0000ABCD, 1'b0, 1'b1, 2'b00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("qfirst_seq_err", seq_err, 1'b1);
        chk("qfirst_dropped", out_valid, 1'b0);

        // I, I, Q: the second I forms the pair.
        send(1'b0, 32'h111, 1'b1, 1'b0, 2'b00);
        send(1'b0, 32'h222, 1'b1, 1'b0, 2'b00);
        send(1'b1, 32'h333, 1'b0, 1'b1, 2'b00);
        pop_check("iiq", 24'h000222, 24'h000333, 1'b0);

        // Errored sample discards the held I, so the following Q is orphaned.
        send(1'b0, 32'h444, 1'b1, 1'b0, 2'b00);
        send(1'b1, 32'h999, 1'b0, 1'b1, 2'b01);
        send(1'b1, 32'h555, 1'b0, 1'b1, 2'b00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("err_drop", out_valid, 1'b0);
        send_pair(32'h666, 32'h777, 0);
        pop_check("after_err", 24'h000666, 24'h000777, 1'b0);

        // Asynchronous reset with three pairs buffered and an I held.
        for (int k = 0; k < 3; k++) send_pair(32'(k + 7), 32'(k + 9), 0);
        send(1'b0, 32'h0BAD, 1'b1, 1'b0, 2'b00);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_i", out_i, 24'h0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_seq_err", seq_err, 1'b0);
        @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_release_ready", in_ready, 1'b1);
        chk("arst_fifo_empty", out_valid, 1'b0);
        send_pair(32'h0ABC, 32'h0DEF, 0);
        pop_check("post_arst", 24'h000ABC, 24'h000DEF, 1'b0);
        chk("post_arst_seq_err", seq_err, 1'b0);

        // Missing SOP flags an error but the pair is still delivered.
        send(1'b0, 32'h1234, 1'b0, 1'b0, 2'b00);
        send(1'b1, 32'h0042, 1'b0, 1'b1, 2'b00);
        pop_check("no_sop", 24'h001234, 24'h000042, 1'b0);
        chk("no_sop_seq_err", seq_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
